// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types and constants for the 4x4 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    // Outcome of one complete four-column scan
    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } scan_res_t;

    localparam int         NUM_ROWS = 4;
    localparam int         NUM_COLS = 4;
    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Active-low one-hot strobe for a column index
    function automatic logic [3:0] col_strobe(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : scan_tick_gen
// Brief    : Prescaler producing the column sample tick and the rotating
//            active-low column strobe.
// Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 40000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       tick,
    output logic [1:0] col_idx,
    output logic [3:0] col_out
);

    localparam int            PW   = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] prescaler;

    // Tick marks the last cycle a column is driven; rows are sampled then
    assign tick    = (prescaler == LAST);
    assign col_out = col_strobe(col_idx);

    // Prescaler wraps on tick and the column advances at the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            col_idx   <= 2'd0;
        end else if (tick) begin
            prescaler <= '0;
            col_idx   <= col_idx + 2'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : 4x4 matrix keypad scanner with scan-level debounce, one hex
//            code per press and a 32-bit shift-in entry register.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 40000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    input  logic        clear,
    output logic [3:0]  col_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_down,
    output logic [31:0] entry
);

    localparam int            CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE);

    logic       tick;
    logic [1:0] col_idx;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick),
        .col_idx (col_idx),
        .col_out (col_out)
    );

    logic [3:0] row_meta, row_sync;

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    logic [1:0] hit_count, scan_count;
    logic [3:0] hit_code, scan_code;
    logic       scan_end;
    scan_res_t  scan_res;

    // Fold the current column's rows into the running scan tally
    always_comb begin
        scan_count = hit_count;
        scan_code  = hit_code;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_sync[r]) begin
                if (scan_count == 2'd0) scan_code = {2'(r), col_idx};
                if (scan_count != 2'd2) scan_count = scan_count + 2'd1;
            end
        end
        scan_end = tick && (col_idx == 2'd3);
        if (scan_count == 2'd0)      scan_res = NONE;
        else if (scan_count == 2'd1) scan_res = SINGLE;
        else                         scan_res = MULTI;
    end

    // Accumulator holds the tally across columns and clears after column 3
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= 2'd0;
            hit_code  <= 4'h0;
        end else if (tick) begin
            if (col_idx == 2'd3) begin
                hit_count <= 2'd0;
                hit_code  <= 4'h0;
            end else begin
                hit_count <= scan_count;
                hit_code  <= scan_code;
            end
        end
    end

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic [3:0]    cand, cand_nx;
    logic          reach, accept, drop;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= 4'h0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            cand  <= cand_nx;
        end
    end

    // Next-state logic; only scan-end results move the FSM
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cand_nx  = cand;
        cnt_inc  = cnt + CW'(1);
        reach    = (cnt_inc == DEB_LAST);
        if (scan_end) begin
            unique case (state)
                IDLE: begin
                    if (scan_res == SINGLE) begin
                        cand_nx  = scan_code;
                        cnt_nx   = CW'(1);
                        state_nx = (DEBOUNCE == 1) ? PRESSED : DEB_PRESS;
                    end
                end
                DEB_PRESS: begin
                    if (scan_res == SINGLE && scan_code == cand) begin
                        if (reach) state_nx = PRESSED;
                        else       cnt_nx   = cnt_inc;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                PRESSED: begin
                    if (scan_res == NONE) begin
                        cnt_nx   = CW'(1);
                        state_nx = (DEBOUNCE == 1) ? IDLE : DEB_RELEASE;
                    end
                end
                DEB_RELEASE: begin
                    if (scan_res == NONE) begin
                        if (reach) state_nx = IDLE;
                        else       cnt_nx   = cnt_inc;
                    end else begin
                        state_nx = PRESSED;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output decode: acceptance and release events from the transition
    always_comb begin
        accept = scan_end && (state == IDLE || state == DEB_PRESS)
                 && (state_nx == PRESSED);
        drop   = scan_end && (state == PRESSED || state == DEB_RELEASE)
                 && (state_nx == IDLE);
    end

    // Registered key outputs; key_valid is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= accept;
            if (accept) key_code <= cand_nx;
            if (accept)    key_down <= 1'b1;
            else if (drop) key_down <= 1'b0;
        end
    end

    // Entry shift register; clear wins over history but keeps a same-cycle key
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= 32'h0;
        end else begin
            unique case ({clear, key_valid})
                2'b01:   entry <= {entry[27:0], key_code};
                2'b10:   entry <= 32'h0;
                2'b11:   entry <= {28'h0, key_code};
                default: entry <= entry;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Self-checking bench for keypad_scanner with a keypad model and
//            an expected-key scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int SCAN     = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [31:0] entry;

    logic [15:0] keys = '0;
    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int pulse_count = 0;
    int last_pulse  = -1;
    logic [3:0] exp_q[$];

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .clear     (clear),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .entry     (entry)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: a held key pulls its row low while its column is strobed
    always_comb begin
        row_in = 4'hF;
        for (int k = 0; k < 16; k++)
            if (keys[k] && !col_out[k % 4]) row_in[k / 4] = 1'b0;
    end

    // Scoreboard: every key_valid pulse must match the oldest expected key
    always @(negedge clk) begin : monitor
        logic [3:0] e;
        if (rst_n && key_valid) begin
            pulse_count++;
            last_pulse = cyc;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: key_code=%h, required no pulse", key_code);
            end else begin
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    n_fail++;
                    $display("FAIL key_code: got %h, expected %h", key_code, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Align to the first negedge of a fresh scan (column 0 just selected)
    task automatic sync_scan(output int t0);
        int n;
        n = 0;
        while (col_out !== 4'b0111 && n < 64) begin @(negedge clk); n++; end
        while (col_out !== 4'b1110 && n < 64) begin @(negedge clk); n++; end
        n_tests++;
        if (n >= 64) begin
            n_fail++;
            $display("FAIL sync_scan: col_out=%b, required rotation within 64 cycles", col_out);
        end
        t0 = cyc;
    endtask

    task automatic press_key(input int code, input int hold, input int idle, output int t0);
        sync_scan(t0);
        exp_q.push_back(code[3:0]);
        keys[code] = 1'b1;
        repeat (hold * SCAN) @(negedge clk);
        keys[code] = 1'b0;
        repeat (idle * SCAN) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] e;
        int p0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (col_out !== 4'b1110) begin n_fail++; $display("FAIL reset_col_out: got %b, expected 1110", col_out); end
        n_tests++; if (entry !== 32'h0) begin n_fail++; $display("FAIL reset_entry: got %h, expected 0", entry); end
        n_tests++; if (key_valid !== 1'b0 || key_down !== 1'b0 || key_code !== 4'h0) begin
            n_fail++; $display("FAIL reset_key_outs: got v=%b d=%b c=%h, expected 0 0 0", key_valid, key_down, key_code);
        end
        p0 = pulse_count;
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            e = 4'b0001 << ((k / 4) % 4);
            n_tests++;
            if (col_out !== ~e) begin
                n_fail++; $display("FAIL col_rotation[%0d]: got %b, expected %b", k, col_out, ~e);
            end
        end
        repeat (184) @(negedge clk);
        n_tests++; if (pulse_count !== p0) begin n_fail++; $display("FAIL idle_no_pulse: got %0d pulses, expected 0", pulse_count - p0); end
    endtask

    task automatic test_single_press();
        int t0, p0;
        p0 = pulse_count;
        press_key(9, 3, 0, t0);
        n_tests++; if (pulse_count !== p0 + 1) begin n_fail++; $display("FAIL single_count: got %0d, expected 1", pulse_count - p0); end
        n_tests++; if (last_pulse !== t0 + 32) begin n_fail++; $display("FAIL single_latency: got %0d, expected %0d", last_pulse - t0, 32); end
        n_tests++; if (entry !== 32'h9) begin n_fail++; $display("FAIL single_entry: got %h, expected 00000009", entry); end
        n_tests++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL single_key_down: got %b, expected 1", key_down); end
        repeat (4 * SCAN) @(negedge clk);
        n_tests++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL single_release: got %b, expected 0", key_down); end
    endtask

    task automatic test_bounce();
        int t0, p0;
        p0 = pulse_count;
        sync_scan(t0);
        exp_q.push_back(4'h3);
        keys[3] = 1'b1; repeat (SCAN) @(negedge clk);
        keys[3] = 1'b0; repeat (SCAN) @(negedge clk);
        keys[3] = 1'b1; repeat (2 * SCAN) @(negedge clk);
        keys[3] = 1'b0; repeat (4 * SCAN) @(negedge clk);
        n_tests++; if (pulse_count !== p0 + 1) begin n_fail++; $display("FAIL bounce_count: got %0d, expected 1", pulse_count - p0); end
        n_tests++; if (last_pulse !== t0 + 64) begin n_fail++; $display("FAIL bounce_latency: got %0d, expected 64", last_pulse - t0); end
        n_tests++; if (entry !== 32'h93) begin n_fail++; $display("FAIL bounce_entry: got %h, expected 00000093", entry); end
    endtask

    task automatic test_release_chain();
        int t0;
        clear = 1'b1; @(negedge clk); clear = 1'b0; @(negedge clk);
        n_tests++; if (entry !== 32'h0) begin n_fail++; $display("FAIL clear_entry: got %h, expected 0", entry); end
        for (int c = 1; c <= 2; c++) begin
            press_key(c, 3, 0, t0);
            repeat (31) @(negedge clk);
            n_tests++; if (key_down !== 1'b1) begin n_fail++; $display("FAIL chain_hold[%0d]: got %b, expected 1", c, key_down); end
            @(negedge clk);
            n_tests++; if (key_down !== 1'b0) begin n_fail++; $display("FAIL chain_fall[%0d]: got %b, expected 0", c, key_down); end
            repeat (SCAN) @(negedge clk);
        end
        n_tests++; if (entry !== 32'h12) begin n_fail++; $display("FAIL chain_entry: got %h, expected 00000012", entry); end
    endtask

    task automatic test_ghost_hold();
        int t0, p0;
        p0 = pulse_count;
        sync_scan(t0);
        keys[0] = 1'b1; keys[4] = 1'b1;
        repeat (3 * SCAN) @(negedge clk);
        keys = '0;
        repeat (2 * SCAN) @(negedge clk);
        n_tests++; if (pulse_count !== p0) begin n_fail++; $display("FAIL ghost_no_pulse: got %0d, expected 0", pulse_count - p0); end
        press_key(5, 10, 4, t0);
        n_tests++; if (pulse_count !== p0 + 1) begin n_fail++; $display("FAIL hold_no_repeat: got %0d, expected 1", pulse_count - p0); end
        n_tests++; if (entry !== 32'h125) begin n_fail++; $display("FAIL hold_entry: got %h, expected 00000125", entry); end
    endtask

    task automatic test_clear_collision();
        int t0;
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        for (int c = 1; c <= 4; c++) press_key(c, 2, 3, t0);
        n_tests++; if (entry !== 32'h1234) begin n_fail++; $display("FAIL pre_collision_entry: got %h, expected 00001234", entry); end
        sync_scan(t0);
        exp_q.push_back(4'hA);
        keys[10] = 1'b1;
        repeat (32) @(negedge clk);
        n_tests++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL collision_pulse: got %b, expected 1", key_valid); end
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        n_tests++; if (entry !== 32'hA) begin n_fail++; $display("FAIL collision_entry: got %h, expected 0000000a", entry); end
        keys = '0;
        repeat (4 * SCAN) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int t0, p0;
        sync_scan(t0);
        exp_q.push_back(4'h5);
        keys[5] = 1'b1;
        repeat (2 * SCAN + 5) @(negedge clk);
        n_tests++; if (key_down !== 1'b1 || entry !== 32'hA5) begin
            n_fail++; $display("FAIL pre_reset_state: got d=%b entry=%h, expected 1 000000a5", key_down, entry);
        end
        rst_n = 1'b0; #1;
        n_tests++; if (col_out !== 4'b1110 || key_code !== 4'h0 || key_valid !== 1'b0 || key_down !== 1'b0 || entry !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset: got col=%b c=%h v=%b d=%b e=%h, expected 1110 0 0 0 0", col_out, key_code, key_valid, key_down, entry);
        end
        keys = '0;
        @(negedge clk); rst_n = 1'b1;
        p0 = pulse_count;
        sync_scan(t0);
        keys[6] = 1'b1;
        repeat (SCAN + 6) @(negedge clk);
        rst_n = 1'b0; keys = '0;
        @(negedge clk); rst_n = 1'b1;
        repeat (4 * SCAN) @(negedge clk);
        n_tests++; if (pulse_count !== p0 || entry !== 32'h0 || key_down !== 1'b0) begin
            n_fail++; $display("FAIL interrupted_press: got pulses=%0d entry=%h d=%b, expected 0 0 0", pulse_count - p0, entry, key_down);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_release_chain();
        test_ghost_hold();
        test_clear_collision();
        test_mid_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d pending keys, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
